lcd_bus_sequencer: RTL and testbench

- Drives the board's HD44780-compatible character LCD bus (RS, RW, E, 8-bit data) directly from fabric logic.
- Runs the power-up initialisation sequence autonomously.
- Then accepts single-byte instruction/data writes over a valid/ready handshake.
- Generates the bus setup, enable-pulse, hold and execution-wait timing for each write.
- Sits beside the Nios II system so that fabric state machines can drive the LCD without the processor.

---
 rtl/lcd_bus_sequencer_pkg.sv | 63 ++++++
 rtl/lcd_bus_sequencer_if.sv | 24 ++
 rtl/lcd_bus_sequencer_timer.sv | 29 ++
 rtl/lcd_bus_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared types and constants for the HD44780 bus sequencer:
// FSM states, latched-byte struct, init ROM, opcode helpers.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    PWRUP_WAIT,
    SETUP,
    E_HIGH,
    HOLD,
    EXEC_WAIT,
    IDLE
  } state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  localparam logic [7:0] CLEAR           = 8'h01;
  localparam logic [7:0] HOME            = 8'h02;
  localparam logic [7:0] FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] DISP_ON         = 8'h0C;
  localparam logic [7:0] ENTRY_INC       = 8'h06;

  localparam int unsigned INIT_LEN = 5;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    FUNC_8BIT_2LINE,
    FUNC_8BIT_2LINE,
    DISP_ON,
    CLEAR,
    ENTRY_INC
  };

  function automatic logic [7:0] init_byte(
    input logic [2:0] i
  );
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < INIT_LEN; k++)
      if (i == 3'(k)) b = INIT_ROM[k];
    return b;
  endfunction

  // 0x03 decodes as "return home" on the
  // controller, so it gets the long wait too.
  function automatic logic is_long_cmd(
    input lcd_byte_t b
  );
    return !b.rs &&
      (b.data == CLEAR ||
       b.data == HOME  ||
       b.data == 8'h03);
  endfunction

  function automatic int unsigned max_of(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// Write-request handshake: requester (master) offers one byte,
// the sequencer (slave) takes it when cmd_ready is high.
interface lcd_bus_sequencer_if;

  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/lcd_bus_sequencer_timer.sv
// Loadable phase down-counter; done is high in the last cycle
// of a phase. Ports: clk, load, load_value in; done out.
module lcd_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A phase of N cycles counts N..1; parks at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_value;
    else if (cnt_q > W'(1))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk)
    cnt_q <= cnt_d;

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 8-bit write sequencer: power-up init, then one byte per
// handshake on cmd; drives RS/RW/E/data/oe with registered outputs.
module lcd_bus_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 3,
  parameter int unsigned T_EPW_CYC   = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_SHORT_CYC = 2000,
  parameter int unsigned T_LONG_CYC  = 82000
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  lcd_bus_sequencer_if.slave  cmd,
  output logic                init_done,
  output logic                busy,
  output logic                lcd_RS,
  output logic                lcd_RW,
  output logic                lcd_E,
  output logic [7:0]          lcd_data,
  output logic                lcd_data_oe
);

  localparam int unsigned T_MAX =
    max_of(max_of(max_of(T_PWRUP_CYC, T_SETUP_CYC),
                  max_of(T_EPW_CYC, T_HOLD_CYC)),
           max_of(T_SHORT_CYC, T_LONG_CYC));
  localparam int unsigned CW = $clog2(T_MAX) + 1;

  state_e     state_q, state_d;
  lcd_byte_t  byte_q, byte_d;
  logic [2:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;

  logic       e_q, e_d;
  logic       rs_q, rs_d;
  logic       oe_q, oe_d;
  logic [7:0] data_q, data_d;

  logic          load;
  logic [CW-1:0] load_value;
  logic          done;

  lcd_phase_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk_clk),
    .load       (load),
    .load_value (load_value),
    .done       (done)
  );

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    load        = 1'b0;
    load_value  = CW'(T_SETUP_CYC);

    unique case (state_q)
      PWRUP_WAIT: begin
        if (done) begin
          state_d = SETUP;
          byte_d  = '{rs: 1'b0, data: init_byte(3'd0)};
          idx_d   = 3'd0;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (done) begin
          state_d    = E_HIGH;
          load       = 1'b1;
          load_value = CW'(T_EPW_CYC);
        end
      end
      E_HIGH: begin
        if (done) begin
          state_d    = HOLD;
          load       = 1'b1;
          load_value = CW'(T_HOLD_CYC);
        end
      end
      HOLD: begin
        if (done) begin
          state_d    = EXEC_WAIT;
          load       = 1'b1;
          load_value = is_long_cmd(byte_q) ?
                       CW'(T_LONG_CYC) :
                       CW'(T_SHORT_CYC);
        end
      end
      EXEC_WAIT: begin
        if (done) begin
          if (!init_done_q &&
              idx_q != 3'(INIT_LEN - 1)) begin
            state_d = SETUP;
            idx_d   = idx_q + 3'd1;
            byte_d  = '{rs: 1'b0,
                        data: init_byte(idx_q + 3'd1)};
            load    = 1'b1;
          end else begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end
        end
      end
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = SETUP;
          byte_d  = '{rs: cmd.cmd_rs,
                      data: cmd.cmd_data};
          load    = 1'b1;
        end
      end
      default: state_d = PWRUP_WAIT;
    endcase

    // Reset reloads the power-up wait in the timer.
    if (!reset_reset_n) begin
      load       = 1'b1;
      load_value = CW'(T_PWRUP_CYC);
    end
  end

  // Outputs follow the next state so they line up
  // with the state they belong to.
  always_comb begin
    oe_d   = (state_d == SETUP)  ||
             (state_d == E_HIGH) ||
             (state_d == HOLD);
    e_d    = (state_d == E_HIGH);
    rs_d   = oe_d & byte_d.rs;
    data_d = oe_d ? byte_d.data : 8'h00;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= PWRUP_WAIT;
      byte_q      <= '0;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      oe_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      oe_q        <= oe_d;
      data_q      <= data_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign init_done     = init_done_q;
  assign lcd_RW        = 1'b0;
  assign lcd_E         = e_q;
  assign lcd_RS        = rs_q;
  assign lcd_data      = data_q;
  assign lcd_data_oe   = oe_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: scoreboard of bus
// writes plus a table of single writes and timing corner cases.
module tb_lcd_bus_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_sequencer_if bus ();

  logic       init_done, busy;
  logic       lcd_RS, lcd_RW, lcd_E, lcd_data_oe;
  logic [7:0] lcd_data;

  lcd_bus_sequencer #(
    .T_PWRUP_CYC (10),
    .T_SETUP_CYC (2),
    .T_EPW_CYC   (3),
    .T_HOLD_CYC  (1),
    .T_SHORT_CYC (5),
    .T_LONG_CYC  (20)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .cmd           (bus),
    .init_done     (init_done),
    .busy          (busy),
    .lcd_RS        (lcd_RS),
    .lcd_RW        (lcd_RW),
    .lcd_E         (lcd_E),
    .lcd_data      (lcd_data),
    .lcd_data_oe   (lcd_data_oe)
  );

  // cyc = 0 in the first cycle with reset released.
  int cyc = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
  } exp_t;

  exp_t exp_q[$];

  localparam int         INIT_RISE [5] = '{12, 23, 34, 45, 71};
  localparam logic [7:0] INIT_BYTE [5] = '{8'h38, 8'h38, 8'h0C,
                                           8'h01, 8'h06};

  int pulses   = 0;
  int acc_n    = 0;
  int last_acc = -1;
  bit e_prev   = 1'b0;
  bit rw_bad   = 1'b0;
  bit early_rd = 1'b0;

  // Monitor: pushes expected writes on accept, pops on E rise.
  always @(negedge clk) begin
    exp_t e;
    if (lcd_RW !== 1'b0) rw_bad = 1'b1;
    if (bus.cmd_ready === 1'b1 && init_done !== 1'b1)
      early_rd = 1'b1;
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 5; i++)
        exp_q.push_back('{1'b0, INIT_BYTE[i], INIT_RISE[i]});
      pulses = 0;
      acc_n  = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_n++;
        last_acc = cyc;
        exp_q.push_back('{bus.cmd_rs, bus.cmd_data, cyc + 3});
      end
      if (lcd_E && !e_prev) begin
        pulses++;
        if (exp_q.size() == 0) begin
          chk("unexpected E pulse", int'({lcd_RS, lcd_data}), -1);
        end else begin
          e = exp_q.pop_front();
          chk("bus byte", int'({lcd_RS, lcd_data}),
              int'({e.rs, e.data}));
          chk("E rise cycle", cyc, e.rise);
          chk("oe at E", int'(lcd_data_oe), 1);
        end
      end
    end
    e_prev = lcd_E;
  end

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) return;
    end
    chk("wait_ready timeout", 0, 1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) return;
      n++;
    end
    chk("count_busy timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offer one byte, return the accept cycle; bytes are
  // scrambled afterwards so a missing latch shows up.
  task automatic write_one(input logic rs,
                           input logic [7:0] d,
                           output int acc);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = d;
    wait_ready();
    acc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = ~rs;
    bus.cmd_data  = ~d;
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int acc, a1, nb;
    logic [10:0] bus_v, bus_x;

    vecs[0] = '{1'b1, 8'h41, 11};
    vecs[1] = '{1'b0, 8'h01, 26};
    vecs[2] = '{1'b0, 8'h80, 11};
    vecs[3] = '{1'b0, 8'h02, 26};
    vecs[4] = '{1'b0, 8'h03, 26};
    vecs[5] = '{1'b1, 8'h01, 11};
    vecs[6] = '{1'b0, 8'h04, 11};

    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs",
        int'({lcd_E, lcd_RS, lcd_data_oe, bus.cmd_ready,
              init_done, busy, lcd_data}),
        int'(14'b0_0_0_0_0_1_00000000));

    // Init with no requests
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready();
    chk("init_done cycle", cyc, 80);
    chk("init_done", int'(init_done), 1);
    @(posedge clk); #1;
    chk("init pulses", pulses, 5);
    chk("init sb drained", exp_q.size(), 0);

    // Request held through reset and init
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h55;
    do_reset(3);
    wait_ready();
    chk("held-req ready cycle", cyc, 80);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("held-req accepts", acc_n, 1);
    chk("held-req accept cyc", last_acc, 80);
    count_busy(nb);
    chk("held-req busy", nb, 11);
    @(posedge clk); #1;
    chk("held-req pulses", pulses, 6);
    chk("held-req sb drained", exp_q.size(), 0);

    // Table of single writes
    for (int i = 0; i < 7; i++) begin
      write_one(vecs[i].rs, vecs[i].data, acc);
      count_busy(nb);
      chk($sformatf("vec%0d busy cycles", i),
          nb, vecs[i].busy_cyc);
    end

    // Cycle-by-cycle bus shape of a data write
    write_one(1'b1, 8'h41, acc);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus_v = {lcd_E, lcd_data_oe, bus.cmd_ready, lcd_data};
      bus_x = {(k >= 3 && k <= 5), (k <= 6), (k == 12),
               (k <= 6) ? 8'h41 : 8'h00};
      chk($sformatf("s2 bus N+%0d", k), int'(bus_v), int'(bus_x));
      if (k <= 6)
        chk($sformatf("s2 RS N+%0d", k), int'(lcd_RS), 1);
    end

    // Back-to-back with valid held high
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h48;
    wait_ready();
    a1 = cyc;
    @(posedge clk); #1;
    bus.cmd_data = 8'h49;
    count_busy(nb);
    chk("b2b busy gap", nb, 11);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("b2b accept spacing", last_acc - a1, 12);
    count_busy(nb);
    chk("b2b second busy", nb, 11);
    @(posedge clk); #1;
    chk("b2b sb drained", exp_q.size(), 0);

    // Reset during the E strobe
    write_one(1'b1, 8'h20, acc);
    for (int i = 0; i < 20 && !lcd_E; i++) @(negedge clk);
    chk("E seen before reset", int'(lcd_E), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset E/oe/done",
        int'({lcd_E, lcd_data_oe, init_done}), 0);
    chk("post-reset busy", int'(busy), 1);
    wait_ready();
    chk("re-init done cycle", cyc, 80);
    @(posedge clk); #1;
    chk("re-init pulses", pulses, 5);
    chk("re-init sb drained", exp_q.size(), 0);

    chk("RW always 0", int'(rw_bad), 0);
    chk("ready before init", int'(early_rd), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
